noc_net_iface: RTL

NOC_NET_IFACE -- requirements
Module: noc_net_iface

---
 rtl/noc_net_iface_pkg.sv | 31 +++
 rtl/noc_sync_fifo.sv | 64 ++++++
 rtl/noc_net_iface.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/noc_net_iface_pkg.sv
// noc_net_iface_pkg
//   Shared constants for the NoC network interface: CPU register offsets,
//   STATUS/CTRL bit positions, counter saturation values and a small helper
//   that clamps a count into the 4-bit STATUS.rx_count field.
package noc_net_iface_pkg;

  // CPU register offsets (4-bit address space)
  localparam logic [3:0] ADDR_TX_DATA = 4'h0;
  localparam logic [3:0] ADDR_DEST    = 4'h4;
  localparam logic [3:0] ADDR_CTRL    = 4'h6;
  localparam logic [3:0] ADDR_RX_DATA = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  // STATUS field positions
  localparam int ST_RX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_ERR    = 2;
  localparam int ST_RX_CNT_LSB = 4;
  localparam int ST_DROP_LSB  = 8;

  // CTRL field positions
  localparam int CTRL_IRQ_EN = 0;

  localparam logic [7:0] DROP_SAT   = 8'hFF;
  localparam logic [3:0] RX_CNT_SAT = 4'hF;

  function automatic logic [3:0] sat_nibble(input logic [31:0] v);
    return (v > 32'(RX_CNT_SAT)) ? RX_CNT_SAT : v[3:0];
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo
//   Single-clock FIFO with first-word-fall-through head output. A push into
//   a full FIFO is still accepted when a pop happens in the same cycle.
//   Pointers wrap naturally because DEPTH is a power of two.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (FIFO empties)
//   push, wdata     write request and data
//   pop             read request (ignored when empty)
//   rdata           current head entry (undefined when empty)
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/noc_net_iface.sv
// noc_net_iface
//   CPU-facing network interface for one NoC tile. The CPU writes flits into
//   a TX FIFO that feeds a registered output stage toward the router; flits
//   arriving from the router are queued in an RX FIFO that the CPU pops by
//   reading RX_DATA.
// Optional feature macro: NOC_NET_IFACE_IRQ_EN
//   defined   -> CTRL.irq_en is implemented, irq = registered irq_en & ~rx_empty
//   undefined -> irq tied low, CTRL reads 0 and ignores writes
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   addr           CPU register offset
//   wdata, we      CPU write data / strobe
//   re             CPU read strobe (only side effect: RX_DATA pop)
//   rdata          combinational read data for addr
//   tx_flit        {valid, dest, payload} toward router
//   tx_ready       router accepts tx_flit this cycle
//   rx_flit        {valid, id, payload} from router
//   irq            packet-arrival interrupt
module noc_net_iface
  import noc_net_iface_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ID_W     = 4,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [31:0]          rdata,
  output logic [ID_W+DATA_W:0] tx_flit,
  input  logic                 tx_ready,
  input  logic [ID_W+DATA_W:0] rx_flit,
  output logic                 irq
);

  localparam int PL_W  = ID_W + DATA_W;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic wr_tx, wr_dest, wr_status, rd_rx;

  assign wr_tx     = we & (addr == ADDR_TX_DATA);
  assign wr_dest   = we & (addr == ADDR_DEST);
  assign wr_status = we & (addr == ADDR_STATUS);
  assign rd_rx     = re & (addr == ADDR_RX_DATA);

  logic [ID_W-1:0] dest_q;
  logic            tx_err_q;
  logic [7:0]      drop_cnt_q;

  // ---------------- TX path ----------------
  logic [PL_W-1:0]  tx_head;
  logic             tx_fifo_full, tx_fifo_empty;
  logic [TX_CW-1:0] tx_fifo_cnt;
  logic [TX_CW-1:0] tx_total;
  logic             tx_valid_q;
  logic [PL_W-1:0]  tx_pl_q;
  logic             tx_drain, tx_load, tx_full, tx_push, tx_err_set;

  // The output register counts toward capacity, so TX_DEPTH flits total can
  // be pending (one presented to the router, the rest queued).
  assign tx_total   = tx_fifo_cnt + TX_CW'(tx_valid_q);
  assign tx_full    = (tx_total == TX_CW'(TX_DEPTH));
  assign tx_drain   = tx_valid_q & tx_ready;
  assign tx_load    = ~tx_fifo_empty & (~tx_valid_q | tx_ready);
  // A drain in the same cycle frees a slot, so a write to a full queue is kept.
  assign tx_push    = wr_tx & (~tx_full | tx_drain) & (~tx_fifo_full | tx_load);
  assign tx_err_set = wr_tx & ~tx_push;

  noc_sync_fifo #(.WIDTH(PL_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_load),
    .wdata ({dest_q, wdata[DATA_W-1:0]}),
    .rdata (tx_head),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty),
    .count (tx_fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_pl_q    <= '0;
    end else if (tx_load) begin
      tx_valid_q <= 1'b1;
      tx_pl_q    <= tx_head;
    end else if (tx_drain) begin
      tx_valid_q <= 1'b0;
      tx_pl_q    <= '0;
    end
  end

  assign tx_flit = {tx_valid_q, tx_pl_q};

  // ---------------- RX path ----------------
  logic [DATA_W-1:0] rx_head;
  logic              rx_full, rx_empty;
  logic [RX_CW-1:0]  rx_cnt;
  logic              rx_push, rx_drop;

  assign rx_push = rx_flit[PL_W];
  // A pop in the same cycle makes room, so only an unserviced full FIFO drops.
  assign rx_drop = rx_push & rx_full & ~rd_rx;

  noc_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rd_rx),
    .wdata (rx_flit[DATA_W-1:0]),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  // ---------------- control registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q     <= '0;
      tx_err_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_dest) dest_q <= wdata[ID_W-1:0];

      if (wr_status)       tx_err_q <= 1'b0;
      else if (tx_err_set) tx_err_q <= 1'b1;

      if (wr_status)                               drop_cnt_q <= '0;
      else if (rx_drop && drop_cnt_q != DROP_SAT)  drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

`ifdef NOC_NET_IFACE_IRQ_EN
  logic wr_ctrl;
  logic irq_en_q;
  logic irq_q;

  assign wr_ctrl = we & (addr == ADDR_CTRL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wdata[CTRL_IRQ_EN];
      irq_q <= irq_en_q & ~rx_empty;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DEST:    rdata[ID_W-1:0] = dest_q;
      ADDR_RX_DATA: if (!rx_empty) rdata[DATA_W-1:0] = rx_head;
      ADDR_STATUS: begin
        rdata[ST_DROP_LSB +: 8]   = drop_cnt_q;
        rdata[ST_RX_CNT_LSB +: 4] = sat_nibble(32'(rx_cnt));
        rdata[ST_TX_ERR]          = tx_err_q;
        rdata[ST_TX_FULL]         = tx_full;
        rdata[ST_RX_EMPTY]        = rx_empty;
      end
`ifdef NOC_NET_IFACE_IRQ_EN
      ADDR_CTRL:    rdata[CTRL_IRQ_EN] = irq_en_q;
`else
      ADDR_CTRL:    rdata[CTRL_IRQ_EN] = 1'b0;
`endif
      default:      rdata = '0;
    endcase
  end

  // Upper write-data bits and the incoming source ID are not stored.
  logic unused_ok;
  assign unused_ok = ^{wdata, rx_flit};

endmodule
